// File: rtl/out_port_fifo_pkg.sv
// Shared constants for the output-port FIFO.
// Status word field positions are derived from the FIFO depth.
package out_port_fifo_pkg;

  localparam int OPF_DATA_WIDTH = 32;
  localparam int OPF_DEPTH      = 4;

  function automatic int ovf_bit(int depth);
    return $clog2(depth) + 3;
  endfunction

  function automatic int full_bit(int depth);
    return $clog2(depth) + 2;
  endfunction

  function automatic int empty_bit(int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int COUNT_LSB = 0;

endpackage

// File: rtl/out_port_fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH registers.
// Synchronous write, asynchronous read, storage is not reset.
module out_port_fifo_mem
  import out_port_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = OPF_DATA_WIDTH,
  parameter int DEPTH      = OPF_DEPTH,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/out_port_fifo.sv
// Output port: bus writes queued in a FIFO, drained over valid/ready.
// Last accepted word and a status word are readable on the bus mux.
module out_port_fifo
  import out_port_fifo_pkg::*;
#(
  parameter int                    DATA_WIDTH = OPF_DATA_WIDTH,
  parameter int                    DEPTH      = OPF_DEPTH,
  parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
  input  logic                  Clock,
  input  logic                  Clear_n,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic                  Strobe,
  input  logic                  ClrOvf,
  output logic [DATA_WIDTH-1:0] Out_Data,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [DATA_WIDTH-1:0] BusMuxIn,
  output logic [DATA_WIDTH-1:0] StatusIn
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OB = ovf_bit(DEPTH);
  localparam int FB = full_bit(DEPTH);
  localparam int EB = empty_bit(DEPTH);

  logic [AW-1:0]         wr_q, wr_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  full, empty;
  logic                  push, pop, rej;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  // Pop frees a slot in the same cycle, so a full FIFO may still accept.
  assign pop  = Out_Valid & Out_Ready;
  assign push = Strobe & (~full | pop);
  assign rej  = Strobe & full & ~pop;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    ovf_d  = ovf_q;
    if (push) begin
      wr_d   = wr_q + AW'(1);
      last_d = BusMuxOut;
    end
    if (pop) rd_d = rd_q + AW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (rej)         ovf_d = 1'b1;
    else if (ClrOvf) ovf_d = 1'b0;
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      last_q <= INIT;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      last_q <= last_d;
    end
  end

  out_port_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk_i   (Clock),
    .we_i    (push),
    .waddr_i (wr_q),
    .wdata_i (BusMuxOut),
    .raddr_i (rd_q),
    .rdata_o (rdata)
  );

  assign Out_Valid = ~empty;
  assign Out_Data  = Out_Valid ? rdata : '0;
  assign BusMuxIn  = last_q;

  always_comb begin
    StatusIn                     = '0;
    StatusIn[COUNT_LSB +: CW]    = cnt_q;
    StatusIn[EB]                 = empty;
    StatusIn[FB]                 = full;
    StatusIn[OB]                 = ovf_q;
  end

endmodule

// File: tb/tb_out_port_fifo.sv
// Scoreboard bench for out_port_fifo (DEPTH=4, 32-bit).
// Expected words are queued at push and compared as the device pops.
module tb_out_port_fifo;

  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] INITV = 32'h1234_5678;

  logic          Clock = 1'b0;
  logic          Clear_n;
  logic [DW-1:0] BusMuxOut;
  logic          Strobe;
  logic          ClrOvf;
  logic [DW-1:0] Out_Data;
  logic          Out_Valid;
  logic          Out_Ready;
  logic [DW-1:0] BusMuxIn;
  logic [DW-1:0] StatusIn;

  out_port_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .INIT       (INITV)
  ) dut (
    .Clock     (Clock),
    .Clear_n   (Clear_n),
    .BusMuxOut (BusMuxOut),
    .Strobe    (Strobe),
    .ClrOvf    (ClrOvf),
    .Out_Data  (Out_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .BusMuxIn  (BusMuxIn),
    .StatusIn  (StatusIn)
  );

  always #5 Clock = ~Clock;

  logic [31:0] q[$];
  logic        m_ovf;
  logic [31:0] m_last;
  int          n_chk;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Status layout for DEPTH=4: ovf[5] full[4] empty[3] count[2:0]
  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'(q.size());
    if (q.size() == 0)     s = s | 32'h08;
    if (q.size() == DEPTH) s = s | 32'h10;
    if (m_ovf)             s = s | 32'h20;
    return s;
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".valid"}, 32'(Out_Valid), 32'(q.size() != 0));
    check({tag, ".data"}, Out_Data, (q.size() != 0) ? q[0] : 32'h0);
    check({tag, ".status"}, StatusIn, exp_status());
    check({tag, ".last"}, BusMuxIn, m_last);
  endtask

  task automatic step(input logic s, input logic [31:0] d,
                      input logic r, input logic c);
    logic full_m, pop_m;
    logic [31:0] w;
    Strobe = s; BusMuxOut = d; Out_Ready = r; ClrOvf = c;
    #1;
    full_m = (q.size() == DEPTH);
    pop_m  = (q.size() != 0) && r;
    if (pop_m) begin
      w = q.pop_front();
      check("pop", Out_Data, w);
    end
    if (s && (!full_m || pop_m)) begin
      q.push_back(d);
      m_last = d;
    end
    if (s && full_m && !pop_m) m_ovf = 1'b1;
    else if (c)                m_ovf = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    check_state("cyc");
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_last = INITV;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    Clear_n = 1'b0; Strobe = 1'b0; BusMuxOut = '0;
    Out_Ready = 1'b0; ClrOvf = 1'b0;
    model_reset();
    repeat (2) @(negedge Clock);
    Clear_n = 1'b1;
    check("rst.status", StatusIn, 32'h0000_0008);
    check_state("rst");
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);

    // single word held while device stalls
    step(1, 32'hDEADBEEF, 0, 0);
    check("t2.data", Out_Data, 32'hDEADBEEF);
    check("t2.last", BusMuxIn, 32'hDEADBEEF);
    repeat (5) step(0, 32'h5555_AAAA, 0, 0);
    check("t2.hold", Out_Data, 32'hDEADBEEF);

    // async reset mid-queue
    step(1, 32'h0BAD_0001, 0, 0);
    #2 Clear_n = 1'b0;
    #1;
    model_reset();
    check("ar.valid", 32'(Out_Valid), 32'h0);
    check("ar.data", Out_Data, 32'h0);
    check("ar.status", StatusIn, 32'h0000_0008);
    check("ar.last", BusMuxIn, INITV);
    @(negedge Clock);
    Clear_n = 1'b1;
    check_state("ar");

    // fill, overflow, clear overflow
    for (int i = 1; i <= 4; i++) step(1, 32'(i), 0, 0);
    check("t3.full", StatusIn, 32'h0000_0014);
    step(1, 32'h5, 0, 0);
    check("t3.ovf", StatusIn, 32'h0000_0034);
    check("t3.last", BusMuxIn, 32'h4);
    step(0, 0, 0, 1);
    check("t3.clr", StatusIn, 32'h0000_0014);
    step(1, 32'h6, 0, 1);
    check("t3.setwins", StatusIn[5], 32'h1 & 32'(1));
    step(0, 0, 0, 1);

    // push into full while popping
    step(1, 32'h9, 1, 0);
    check("t4.cnt", StatusIn, 32'h0000_0014);
    check("t4.head", Out_Data, 32'h2);
    repeat (4) step(0, 0, 1, 0);
    check("t4.empty", StatusIn, 32'h0000_0008);

    // streaming with pointer wrap
    for (int i = 1; i <= 8; i++) step(1, 32'(i), 1, 0);
    step(0, 0, 1, 0);
    check("t5.empty", StatusIn, 32'h0000_0008);
    check("t5.last", BusMuxIn, 32'h8);

    // ready while empty has no effect
    step(0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), $urandom(),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
